// File: rtl/dispense_servo_if.sv
// dispense_servo_if: request/status bundle between a dispenser channel and its servo driver.
// DISPENSE_TALLY_EN adds the 16-bit dispensed-dose tally.
interface dispense_servo_if;
  logic       dispense_req;
  logic [2:0] dose_count;
  logic       override;
  logic       servo_pwm;
  logic       busy;
  logic       dose_pulse;
  logic       done;
  logic [2:0] doses_left;
  logic       overrun;
`ifdef DISPENSE_TALLY_EN
  logic [15:0] tally;
`endif
  modport master (
    output dispense_req, dose_count, override,
    input  servo_pwm, busy, dose_pulse, done, doses_left, overrun
`ifdef DISPENSE_TALLY_EN
    , tally
`endif
  );
  modport slave (
    input  dispense_req, dose_count, override,
    output servo_pwm, busy, dose_pulse, done, doses_left, overrun
`ifdef DISPENSE_TALLY_EN
    , tally
`endif
  );
endinterface

// File: rtl/dispense_servo_driver.sv
// dispense_servo_driver: turns dose requests into 50 Hz servo open/close strokes.
// DISPENSE_TALLY_EN adds a saturating count of dispensed doses.
module dispense_servo_driver #(
  parameter int PERIOD_CYC   = 1_000_000,
  parameter int PULSE_CLOSED = 50_000,
  parameter int PULSE_OPEN   = 100_000,
  parameter int HOLD_FRAMES  = 25,
  parameter int GAP_FRAMES   = 25
) (
  input logic             CLOCK_50,
  input logic             reset,
  dispense_servo_if.slave srv
);
  localparam int FW = $clog2(PERIOD_CYC);
  localparam int HW = $clog2((HOLD_FRAMES > GAP_FRAMES ? HOLD_FRAMES : GAP_FRAMES) + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OPEN = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [FW-1:0] W_OPEN   = FW'(PULSE_OPEN);
  localparam logic [FW-1:0] W_CLOSED = FW'(PULSE_CLOSED);
  localparam logic [FW-1:0] F_LAST   = FW'(PERIOD_CYC - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(HOLD_FRAMES - 1);
  localparam logic [HW-1:0] G_LAST   = HW'(GAP_FRAMES - 1);

  logic [FW-1:0] frame_q, frame_d, width_q, width_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    state_q, state_d;
  logic [2:0]    left_q, left_d, queue_q, queue_d;
  logic          queued_q, queued_d, pending_q, pending_d, busy_q, busy_d;
  logic          pwm_q, pwm_d, dose_q, dose_d, done_q, done_d, overrun_q, overrun_d;
  logic          boundary, req_ok, hold_end;

  always_comb begin
    boundary  = frame_q == F_LAST;
    req_ok    = srv.dispense_req && srv.dose_count != 3'd0;
    hold_end  = hold_q == (state_q == S_OPEN ? H_LAST : G_LAST);
    frame_d   = boundary ? '0 : frame_q + 1'b1;
    pwm_d     = frame_q < width_q;
    width_d   = width_q;
    hold_d    = hold_q;
    state_d   = state_q;
    left_d    = left_q;
    queue_d   = queue_q;
    queued_d  = queued_q;
    pending_d = pending_q;
    busy_d    = busy_q;
    dose_d    = 1'b0;
    done_d    = 1'b0;
    overrun_d = 1'b0;
    if (req_ok) begin
      if (!busy_q) begin
        left_d    = srv.dose_count;
        pending_d = 1'b1;
        busy_d    = 1'b1;
      end else if (!queued_q) begin
        queue_d  = srv.dose_count;
        queued_d = 1'b1;
      end else
        overrun_d = 1'b1;
    end
    // Override freezes the sequencer; it only forces the pulse width below.
    if (boundary && !srv.override) begin
      if (state_q == S_IDLE) begin
        if (pending_q) begin
          state_d   = S_OPEN;
          hold_d    = '0;
          pending_d = 1'b0;
        end
      end else if (!hold_end)
        hold_d = hold_q + 1'b1;
      else if (state_q == S_GAP) begin
        state_d = S_OPEN;
        hold_d  = '0;
      end else begin
        dose_d  = 1'b1;
        hold_d  = '0;
        left_d  = left_q - 3'd1;
        state_d = S_GAP;
        if (left_q == 3'd1) begin
          done_d = 1'b1;
          // A queued count (or one arriving right now) restarts without an idle frame.
          if (queued_q || req_ok) begin
            left_d   = queued_q ? queue_q : srv.dose_count;
            queued_d = 1'b0;
            state_d  = S_OPEN;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
    end
    if (boundary)
      width_d = (srv.override || state_d == S_OPEN) ? W_OPEN : W_CLOSED;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      frame_q   <= '0;
      width_q   <= W_CLOSED;
      hold_q    <= '0;
      state_q   <= S_IDLE;
      left_q    <= '0;
      queue_q   <= '0;
      queued_q  <= 1'b0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      pwm_q     <= 1'b0;
      dose_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      frame_q   <= frame_d;
      width_q   <= width_d;
      hold_q    <= hold_d;
      state_q   <= state_d;
      left_q    <= left_d;
      queue_q   <= queue_d;
      queued_q  <= queued_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      pwm_q     <= pwm_d;
      dose_q    <= dose_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign srv.servo_pwm  = pwm_q;
  assign srv.busy       = busy_q;
  assign srv.dose_pulse = dose_q;
  assign srv.done       = done_q;
  assign srv.doses_left = left_q;
  assign srv.overrun    = overrun_q;

`ifdef DISPENSE_TALLY_EN
  logic [15:0] tally_q;
  always_ff @(posedge CLOCK_50) begin
    if (reset)
      tally_q <= '0;
    else if (dose_q && tally_q != 16'hFFFF)
      tally_q <= tally_q + 16'd1;
  end
  assign srv.tally = tally_q;
`endif
endmodule
